jesd204_soft_pcs_comma_align: RTL
=================================

// Module: jesd204_soft_pcs_comma_align
// PURPOSE
//  Soft-PCS RX word aligner sitting between the SERDES parallel output and jesd204_8b10b_decoder.
//  Finds K28.x comma patterns in the unaligned raw bit stream and applies a bit-slip.
//  Each output 10-bit slot then carries exactly one code-group ready for decoding.
//  Reports lock status and per-slot comma flags to the CGS logic downstream.
// PARAMETERS
//  DATA_PATH_WIDTH  4  10-bit symbols per clock; raw bus is 10*DATA_PATH_WIDTH bits, bit 0 first on wire
//  LOCK_COUNT       4  consecutive comma-bearing cycles at one offset required to assert out_locked (1..15)
// PORTS
//  clk             in   1      lane clock
//  reset           in   1      synchronous, active-high
//  in_raw          in   10*W   unaligned SERDES bits, bit 0 = earliest
//  align_enable    in   1      1: offset may change; 0: offset frozen
//  out_raw         out  10*W   aligned code-groups, slot i = bits [10i+9:10i], bit 0 = 'a'
//  out_comma       out  W      slot i holds comma at aligned position
//  out_locked      out  1      alignment stable
//  out_offset      out  4      current bit-slip, 0..9
// BEHAVIOUR
//  Clock and reset
//   - One clock.
//   - Reset is synchronous and active-high.
//   - Reset values: out_raw=0, out_comma=0, out_locked=0, out_offset=0, consecutive counter=0, prev word=0.
//  Windowing
//   - prev_q <= in_raw each cycle.
//   - window = {in_raw, prev_q}, 20*W bits.
//   - Aligned word = window[offset + 10*W - 1 : offset].
//  Comma detection
//   - Done on window bit positions p = 0..10*W-1.
//   - Match when window[p+6:p] == 7'b1111100 (abcdeif=0011111) or == 7'b0000011 (1100000).
//   - cand = lowest matching p; cand_off = cand mod 10. No match -> no candidate.
//   - Multiple matches at differing phases: lowest p wins; that cycle counts as misaligned unless all match phases equal offset.
//  State machine
//   - UNLOCKED:
//     - Candidate with cand_off==offset: cnt++.
//     - cand_off!=offset and align_enable: offset<=cand_off, cnt<=1.
//     - No candidate: cnt held.
//     - cnt reaching LOCK_COUNT: -> LOCKED, out_locked<=1.
//   - LOCKED:
//     - Candidate with cand_off!=offset and align_enable: offset<=cand_off, cnt<=1, out_locked<=0, -> UNLOCKED.
//     - Otherwise stay.
//   - align_enable=0: offset never changes; the lock counter still runs on in-phase commas.
//   - cnt saturates at LOCK_COUNT.
//  Latency
//   - Registered output: out_raw/out_comma are one clk after the in_raw beat that completes the window.
//   - A new offset applies from the next cycle's output onward.
//   - The beat carrying the slip is output with the old offset; no bits are duplicated beyond that.
//  out_comma
//   - Computed on the aligned word with the offset in use for that output, slot-wise [6:0] compare.
//  Boundary cases
//   - Comma straddling the cycle boundary is covered by prev_q.
//   - Offset 9 with W=1 stays within the 20-bit window.
//   - Reset mid-stream drops lock and clears offset in the same cycle.
// STRUCTURE
//  - Shared package/header: comma pattern constants (COMMA_P=7'b1111100, COMMA_N=7'b0000011), symbol width 10.
//  - The same header is included by the 8b10b encoder/decoder and CGS logic.
//  - One natural sub-module, jesd204_soft_pcs_comma_detect: combinational priority scan of the window.
//    - Outputs found and cand_off.
//    - Instantiated once; the per-slot out_comma compare is inline.
//  - Barrel shift and FSM live in this module; target 150-250 lines.
// TESTING
//  Drive the bench from jesd204_8b10b_encoder output, bit-rotated by a chosen slip.
//  1. W=4, K28.5 stream (RD alternating), slip 3
//     -> out_offset=3 after first comma cycle.
//     -> out_locked=1 after 4 comma cycles.
//     -> out_raw slots equal encoder words; out_comma=4'b1111.
//  2. Lock at slip 3, then insert 1 bit (slip becomes 4) with align_enable=1
//     -> out_locked falls next cycle, out_offset=4, relock after 4 cycles.
//     -> Decoder notintable=0 on all post-relock slots.
//  3. Same slip change with align_enable=0
//     -> out_offset stays 3, out_locked stays 1, out_comma=0.
//  4. Comma straddling cycle boundary, W=1, slip 7
//     -> detected, out_offset=7, aligned K28.5 = 10'b0101111100 (RD-) in out_raw.
//  5. Random data containing no comma, 1000 cycles
//     -> out_offset unchanged from reset (0), out_locked=0.
//  6. Assert reset while locked, mid-stream
//     -> next cycle out_locked=0, out_offset=0, out_raw=0.
//     -> Relock after LOCK_COUNT comma cycles once released.

Source files
------------

// File: rtl/jesd204_soft_pcs_comma_align_pkg.sv
// Shared soft-PCS definitions: symbol width, K28.x comma patterns and aligner state encoding.
// Also included by the 8b10b encoder/decoder and the CGS logic.
package jesd204_soft_pcs_comma_align_pkg;

  localparam int SYM_W = 10;

  // Seven-bit comma prefix, bit 0 = 'a' (first on the wire).
  localparam logic [6:0] COMMA_P = 7'b1111100;  // abcdeif = 0011111
  localparam logic [6:0] COMMA_N = 7'b0000011;  // abcdeif = 1100000

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } align_state_e;

  function automatic logic is_comma(input logic [6:0] bits);
    return (bits == COMMA_P) || (bits == COMMA_N);
  endfunction

endpackage

// File: rtl/jesd204_soft_pcs_comma_detect.sv
// Combinational priority scan of the two-beat window for K28.x commas.
// Reports the lowest matching bit position's phase plus the set of all phases seen.
module jesd204_soft_pcs_comma_detect
  import jesd204_soft_pcs_comma_align_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic [2*SYM_W*DATA_PATH_WIDTH-1:0] window_i,
  output logic                               found_o,
  output logic [3:0]                         cand_off_o,
  output logic [SYM_W-1:0]                   phase_mask_o
);

  localparam int SCAN_N = SYM_W * DATA_PATH_WIDTH;

  logic [3:0] ph;

  // Scan from the top down so the lowest matching position is written last.
  always_comb begin
    found_o      = 1'b0;
    cand_off_o   = '0;
    phase_mask_o = '0;
    ph           = '0;
    for (int p = SCAN_N - 1; p >= 0; p--) begin
      ph = 4'(p % SYM_W);
      if (is_comma(window_i[p +: 7])) begin
        found_o          = 1'b1;
        cand_off_o       = ph;
        phase_mask_o[ph] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jesd204_soft_pcs_comma_align.sv
// Soft-PCS RX word aligner: locates K28.x commas in the raw SERDES stream, bit-slips the
// parallel word so every 10-bit slot holds one code-group, and reports lock and comma flags.
module jesd204_soft_pcs_comma_align
  import jesd204_soft_pcs_comma_align_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int LOCK_COUNT      = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [SYM_W*DATA_PATH_WIDTH-1:0]   in_raw,
  input  logic                               align_enable,
  output logic [SYM_W*DATA_PATH_WIDTH-1:0]   out_raw,
  output logic [DATA_PATH_WIDTH-1:0]         out_comma,
  output logic                               out_locked,
  output logic [3:0]                         out_offset
);

  localparam int         RAW_W    = SYM_W * DATA_PATH_WIDTH;
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  align_state_e               state_q, state_d;
  logic [3:0]                 offset_q, offset_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [RAW_W-1:0]           prev_q;
  logic [RAW_W-1:0]           raw_q;
  logic [DATA_PATH_WIDTH-1:0] comma_q, comma_d;

  logic [2*RAW_W-1:0] window;
  logic [RAW_W-1:0]   aligned;
  logic               found;
  logic [3:0]         cand_off;
  logic [SYM_W-1:0]   phase_mask;
  logic               in_phase;
  logic               slip;
  logic [3:0]         cnt_inc;

  // Previous beat supplies the bits ahead of the current one, covering commas that straddle beats.
  assign window  = {in_raw, prev_q};
  assign aligned = RAW_W'(window >> offset_q);

  jesd204_soft_pcs_comma_detect #(
    .DATA_PATH_WIDTH(DATA_PATH_WIDTH)
  ) u_detect (
    .window_i    (window),
    .found_o     (found),
    .cand_off_o  (cand_off),
    .phase_mask_o(phase_mask)
  );

  // A cycle only counts toward lock when every comma seen sits at the current offset.
  assign in_phase = found && (phase_mask == (10'd1 << offset_q));
  assign slip     = found && (cand_off != offset_q) && align_enable;
  assign cnt_inc  = (cnt_q >= LOCK_CNT) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    comma_d = '0;
    for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
      comma_d[i] = is_comma(aligned[SYM_W*i +: 7]);
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (slip) begin
          offset_d = cand_off;
          cnt_d    = 4'd1;
          if (LOCK_CNT <= 4'd1) state_d = ST_LOCKED;
        end else if (in_phase) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= LOCK_CNT) state_d = ST_LOCKED;
        end else if (found) begin
          cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (slip) begin
          offset_d = cand_off;
          cnt_d    = 4'd1;
          state_d  = ST_UNLOCKED;
        end else if (in_phase) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // The beat that triggers a slip is still emitted with the old offset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_UNLOCKED;
      offset_q <= '0;
      cnt_q    <= '0;
      prev_q   <= '0;
      raw_q    <= '0;
      comma_q  <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      prev_q   <= in_raw;
      raw_q    <= aligned;
      comma_q  <= comma_d;
    end
  end

  assign out_raw    = raw_q;
  assign out_comma  = comma_q;
  assign out_locked = (state_q == ST_LOCKED);
  assign out_offset = offset_q;

endmodule
